// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low column at a time, samples the
// active-low rows at the end of each dwell, and debounces whole frames into key events.
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] row_in_i,
  output logic [3:0] col_out_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_held_o
);

  // state        | meaning
  // S_IDLE       | no key accepted, waiting for a single-key frame
  // S_DEB_PRESS  | same single key seen on cnt consecutive frames
  // S_PRESSED    | key_code accepted and still closed
  // S_DEB_RELEASE| key_code missing for cnt consecutive frames
  typedef enum logic [1:0] {
    S_IDLE,
    S_DEB_PRESS,
    S_PRESSED,
    S_DEB_RELEASE
  } state_t;

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CNT);

  state_t        state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    hits_q, hits_d;
  logic [3:0]    hit_code_q, hit_code_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;

  logic          sample;
  logic          frame_end;
  logic [3:0]    lows;
  logic [2:0]    n_low;
  logic [1:0]    row_idx;
  logic [2:0]    frame_hits;
  logic [3:0]    frame_code;
  logic          frame_single;
  logic [CW-1:0] press_cnt;
  logic [CW-1:0] rel_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      dwell_q     <= '0;
      col_q       <= '0;
      hits_q      <= '0;
      hit_code_q  <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      col_q       <= col_d;
      hits_q      <= hits_d;
      hit_code_q  <= hit_code_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  // Column scan and per-frame closure accumulation.
  always_comb begin
    sample    = (dwell_q == DWELL_LAST);
    frame_end = sample && (col_q == 2'd3);
    lows      = ~row_in_i;
    n_low     = '0;
    row_idx   = '0;
    for (int r = 0; r < 4; r++) begin
      if (lows[r]) begin
        n_low   = n_low + 3'd1;
        row_idx = 2'(r);
      end
    end
    frame_hits   = 3'(hits_q) + n_low;
    frame_code   = (n_low != 3'd0) ? {row_idx, col_q} : hit_code_q;
    frame_single = (frame_hits == 3'd1);

    dwell_d    = sample ? '0 : dwell_q + DW'(1);
    col_d      = sample ? col_q + 2'd1 : col_q;
    hits_d     = hits_q;
    hit_code_d = hit_code_q;
    if (sample) begin
      if (frame_end) begin
        hits_d     = '0;
        hit_code_d = '0;
      end else begin
        // Saturate at 2: anything beyond "more than one" classifies the same.
        hits_d = (frame_hits >= 3'd2) ? 2'd2 : frame_hits[1:0];
        if (n_low != 3'd0) hit_code_d = {row_idx, col_q};
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    press_cnt   = CW'(1);
    rel_cnt     = CW'(1);
    if (frame_end) begin
      unique case (state_q)
        S_IDLE, S_DEB_PRESS: begin
          if (frame_single) begin
            if (state_q == S_DEB_PRESS && frame_code == cand_q) press_cnt = cnt_q + CW'(1);
            cand_d = frame_code;
            if (press_cnt >= DEB_LAST) begin
              state_d     = S_PRESSED;
              key_code_d  = frame_code;
              key_valid_d = 1'b1;
              cnt_d       = '0;
            end else begin
              state_d = S_DEB_PRESS;
              cnt_d   = press_cnt;
            end
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_PRESSED, S_DEB_RELEASE: begin
          if (frame_single && frame_code == key_code_q) begin
            state_d = S_PRESSED;
            cnt_d   = '0;
          end else begin
            if (state_q == S_DEB_RELEASE) rel_cnt = cnt_q + CW'(1);
            if (rel_cnt >= DEB_LAST) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = S_DEB_RELEASE;
              cnt_d   = rel_cnt;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign col_out_o   = ~(4'b0001 << col_q);
  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;
  assign key_held_o  = (state_q == S_PRESSED) || (state_q == S_DEB_RELEASE);

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart to the multiplexed seven-segment display driver: scans a 4x4 matrix keypad by driving one active-low column select at a time and reading four active-low row returns.
- Debounces across whole scan frames and emits a one-cycle `key_valid` strobe with a 4-bit key code per clean press.
- Sits beside the display path in the top level; `key_code`/`key_valid` feed the counter/adder logic as user input.

Parameters:
- SCAN_DIV, 50000: clock cycles each column is driven (dwell); must be >= 2.
- DEBOUNCE_CNT, 4: consecutive identical frames required to accept a press or a release; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- row_in  in  4  keypad row returns, active-low (0 = key closed on the currently driven column); externally pulled up; assumed already synchronised.
- col_out  out  4  column drive, active-low one-hot; bit c low = column c driven.
- key_code  out  4  last accepted key, {row_idx[1:0], col_idx[1:0]}.
- key_valid  out  1  one-cycle pulse when a press is accepted.
- key_held  out  1  high while an accepted key is considered down.

Behaviour:
- Reset values (all synchronous to clk): `col_out`=4'b1110, `key_code`=0, `key_valid`=0, `key_held`=0, FSM=IDLE, all counters 0, frame accumulators cleared.
- Scan:
  - Dwell counter counts 0..SCAN_DIV-1 per column; column index 0..3, wraps 3->0.
  - `col_out` changes on the edge after dwell count SCAN_DIV-1.
  - `row_in` is sampled only at dwell count SCAN_DIV-1 (settled value).
- Frame:
  - One frame = 4 columns = 4*SCAN_DIV cycles.
  - Per sample, count the low `row_in` bits and record {row,col} of a hit.
  - At the end of the column-3 sample the frame is classified: NONE (0 closures), SINGLE(code) (exactly 1), MULTI (>=2, ghosting).
- FSM (updates on the frame-end edge only):
  - IDLE: SINGLE(k) -> DEB_PRESS, cand=k, cnt=1; otherwise stay.
  - DEB_PRESS:
    - SINGLE(cand): cnt+1; when cnt reaches DEBOUNCE_CNT -> PRESSED, `key_code`<=cand, `key_valid` pulses.
    - SINGLE(other) restarts with the new cand, cnt=1.
    - NONE -> IDLE.
    - MULTI -> IDLE.
  - PRESSED: any frame other than SINGLE(`key_code`) -> DEB_RELEASE, cnt=1; SINGLE(`key_code`) stays.
  - DEB_RELEASE:
    - SINGLE(`key_code`) -> PRESSED, no new pulse.
    - Any other frame: cnt+1; at DEBOUNCE_CNT -> IDLE.
- With DEBOUNCE_CNT=1, a single qualifying frame accepts or releases.
- Outputs:
  - `key_valid` is high exactly one clk cycle, the cycle after the accepting frame-end edge; never two pulses without passing through IDLE.
  - `key_held`=1 in PRESSED and DEB_RELEASE.
  - `key_code` holds its value after release until the next accepted press.
- Latency: a key closed stably from a frame start produces `key_valid` DEBOUNCE_CNT frames later (DEBOUNCE_CNT*4*SCAN_DIV cycles, +1 for the registered pulse).
- Key change while held: a different key must pass through release debounce to IDLE, then press debounce from the next frame.
- Reset mid-operation (any state, any dwell count): next cycle all outputs and state equal reset values; scanning restarts at column 0.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3, frame=16 cycles):
- Reset, `row_in`=4'hF -> `col_out` 1110, 1101, 1011, 0111, changing every 4 cycles, back to 1110 at cycle 16; `key_valid`/`key_held`/`key_code` stay 0.
- Row 2 pulled low whenever `col_out[1]`=0, held 6 frames -> exactly one `key_valid` pulse after frame 3 end; `key_code`=4'h9; `key_held`=1 until stimulus ends.
- Bounce: key 9 present on alternate frames (1 on, 1 off, x5) -> no `key_valid`; `key_held` stays 0.
- Release after case 2: `row_in`=F for 3 frames -> `key_held` falls after the 3rd frame end; `key_code` remains 4'h9. A 1-frame dropout mid-hold returns to PRESSED with no extra pulse.
- Ghosting: rows 0 and 3 low on column 2 for 5 frames -> no `key_valid`. Key row 0/col 0 closed then adding a 2nd key before frame 3 -> no pulse.
- Reset at frame 2 of press debounce -> next cycle `col_out`=1110 and outputs 0. Key kept closed afterwards -> pulse 3 full frames after reset with `key_code` correct.
